fft_bitrev_reorder: RTL and testbench



---
 rtl/fft_bitrev_reorder_if.sv | 31 +++
 rtl/fft_bitrev_reorder.sv | 111 +++++++++++
 tb/tb_fft_bitrev_reorder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bitrev_reorder_if.sv
// fft_bitrev_reorder_if
// Sample-stream interface of the FFT bit-reversal reorder stage.
//   in_valid/in_ready/in_r/in_i     : upstream samples (bit-reversed order)
//   out_valid/out_ready/out_r/out_i : downstream samples (natural order)
//   out_last                        : marks natural index N-1 of each frame
// Modports:
//   slave  : the reorder block (consumes the input stream, produces the output)
//   master : the environment (drives the input stream, accepts the output)
interface fft_bitrev_reorder_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] in_i;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_r;
  logic [DATA_W-1:0] out_i;
  logic              out_last;

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_last
  );

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_last
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
// Output stage of the radix-2 FFT. Frames arrive in bit-reversed index order,
// are buffered in a ping-pong pair of N-entry banks and re-emitted in natural
// index order. Two banks sustain one sample per cycle.
// Ports:
//   clk    : system clock, all state changes on posedge
//   reset  : synchronous, active-high reset
//   enable : global stage enable; low suppresses both handshakes, state holds
//   io     : sample-stream interface (slave side), see fft_bitrev_reorder_if
module fft_bitrev_reorder #(
  parameter int LOG2N  = 3,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  fft_bitrev_reorder_if.slave io
);
  localparam int               N        = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] i;
  } sample_t;

  sample_t          mem_q [2][N];
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;

  logic             accept;
  logic             xfer;
  logic [LOG2N-1:0] wr_addr;

  // Handshakes depend only on registered state, so a bank freed this cycle
  // becomes writable next cycle. Reset is folded in so both stay low while
  // reset is asserted, even before the first reset edge has cleared state.
  assign io.in_ready  = !reset && enable && !full_q[wr_bank_q];
  assign io.out_valid = !reset && enable && full_q[rd_bank_q];
  assign io.out_last  = io.out_valid && (rd_cnt_q == LAST_IDX);
  assign io.out_r     = mem_q[rd_bank_q][rd_cnt_q].r;
  assign io.out_i     = mem_q[rd_bank_q][rd_cnt_q].i;

  assign accept = io.in_valid && io.in_ready;
  assign xfer   = io.out_valid && io.out_ready;

  // Arrival k of a frame belongs at natural index bitrev(k).
  always_comb begin
    for (int k = 0; k < LOG2N; k++) begin
      wr_addr[k] = wr_cnt_q[LOG2N-1-k];
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;

    if (accept) begin
      wr_cnt_d = wr_cnt_q + ONE;
      if (wr_cnt_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // The write bank is never full and the read bank always is, so the two
    // updates below never touch the same flag bit.
    if (xfer) begin
      rd_cnt_d = rd_cnt_q + ONE;
      if (rd_cnt_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  // NOTE: sample storage has no reset; the full flags guarantee a bank is
  // never read before it has been completely written.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_bank_q][wr_addr] <= '{r: io.in_r, i: io.in_i};
    end
  end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder
// Directed bench for fft_bitrev_reorder (LOG2N=3, DATA_W=16). Arrival k of
// frame f carries r = ((f%16)*8 + k)*256, i = -r; the natural-order output at
// position n therefore carries arrival br_tab[n] of the same frame.
module tb_fft_bitrev_reorder;
  localparam int DATA_W = 16;
  localparam int BUDGET = 2000;

  logic clk;
  logic reset;
  logic enable;

  fft_bitrev_reorder_if #(.DATA_W(DATA_W)) bus ();

  fft_bitrev_reorder #(.LOG2N(3), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .io     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed 3-bit reversal: output position n holds arrival br_tab[n].
  int br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  int n_vec = 0;
  int n_err = 0;

  int frame_base = 0;
  int first_low_at;
  int ready_low_cycles;
  int last_cyc [$];

  function automatic int sample_val(input int f, input int k);
    return ((f % 16) * 8 + k) * 256;
  endfunction

  // Streams n_frames frames through the block with the chosen out_ready
  // pattern (0: always 1, 1: random, 2: low for the first rdy_hold cycles) and
  // optional 3-cycle enable gaps, checking every output on the way.
  task automatic stream(input int n_frames, input int rdy_mode, input int rdy_hold,
                        input int gap_a, input int gap_b);
    int total = n_frames * 8;
    int sent = 0, got = 0, cyc = 0, fill_cyc = -1;
    int f, n, v;
    bit stalled = 0, last_free = 0, exp_last;
    logic [DATA_W-1:0] exp_r, exp_i, held_r, held_i;
    logic held_last;
    first_low_at     = -1;
    ready_low_cycles = 0;
    last_cyc.delete();
    while ((sent < total || got < total) && cyc < BUDGET) begin
      @(negedge clk);
      enable = !((gap_a >= 0 && cyc >= gap_a && cyc < gap_a + 3) ||
                 (gap_b >= 0 && cyc >= gap_b && cyc < gap_b + 3));
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (cyc >= rdy_hold);
      endcase
      #1;
      if (!enable) begin
        n_vec++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL enable_gap cyc %0d: in_ready=%b out_valid=%b, want 0 0",
                   cyc, bus.in_ready, bus.out_valid);
        end
      end
      if (enable && fill_cyc >= 0 && cyc == fill_cyc + 1) begin
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL latency cyc %0d: out_valid=%b, want 1", cyc, bus.out_valid);
        end
      end else if (fill_cyc < 0) begin
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL early_valid cyc %0d: out_valid=%b, want 0", cyc, bus.out_valid);
        end
      end
      if (stalled && bus.out_valid === 1'b1) begin
        n_vec++;
        if (bus.out_r !== held_r || bus.out_i !== held_i || bus.out_last !== held_last) begin
          n_err++;
          $display("FAIL stall_hold cyc %0d: got %0d/%0d/%b, want %0d/%0d/%b", cyc,
                   $signed(bus.out_r), $signed(bus.out_i), bus.out_last,
                   $signed(held_r), $signed(held_i), held_last);
        end
      end
      if (last_free && enable && sent < total) begin
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL ready_after_free cyc %0d: in_ready=%b, want 1", cyc, bus.in_ready);
        end
      end
      last_free = 0;
      stalled   = 0;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        f = frame_base + got / 8;
        n = got % 8;
        v = sample_val(f, br_tab[n]);
        exp_r    = DATA_W'(v);
        exp_i    = DATA_W'(-v);
        exp_last = (n == 7);
        n_vec++;
        if (bus.out_r !== exp_r || bus.out_i !== exp_i || bus.out_last !== exp_last) begin
          n_err++;
          $display("FAIL out_sample #%0d: got %0d/%0d/%b, want %0d/%0d/%b", got,
                   $signed(bus.out_r), $signed(bus.out_i), bus.out_last,
                   $signed(exp_r), $signed(exp_i), exp_last);
        end
        if (exp_last) begin
          last_cyc.push_back(cyc);
          last_free = 1;
        end
        got++;
      end else if (bus.out_valid === 1'b1) begin
        stalled   = 1;
        held_r    = bus.out_r;
        held_i    = bus.out_i;
        held_last = bus.out_last;
      end
      if (sent < total) begin
        v = sample_val(frame_base + sent / 8, sent % 8);
        bus.in_valid = 1'b1;
        bus.in_r     = DATA_W'(v);
        bus.in_i     = DATA_W'(-v);
        if (bus.in_ready === 1'b1) begin
          sent++;
          if (sent == 8) fill_cyc = cyc;
        end else if (enable) begin
          ready_low_cycles++;
          if (first_low_at < 0) first_low_at = sent;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    enable       = 1'b1;
    if (cyc >= BUDGET) begin
      n_err++;
      $display("FAIL stream_timeout: sent %0d got %0d, want %0d each", sent, got, total);
    end
    frame_base += n_frames;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_r = '0;
    bus.in_i = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b out_last=%b, want 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_last);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_single_frame();
    stream(1, 0, 0, -1, -1);
    n_vec++;
    if (last_cyc.size() != 1) begin
      n_err++;
      $display("FAIL single_last_count: got %0d, want 1", last_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    stream(4, 0, 0, -1, -1);
    n_vec++;
    if (ready_low_cycles != 0) begin
      n_err++;
      $display("FAIL b2b_ready_low: got %0d low cycles, want 0", ready_low_cycles);
    end
    n_vec++;
    if (last_cyc.size() != 4) begin
      n_err++;
      $display("FAIL b2b_last_count: got %0d, want 4", last_cyc.size());
    end else begin
      for (int j = 1; j < 4; j++) begin
        n_vec++;
        if (last_cyc[j] - last_cyc[j-1] != 8) begin
          n_err++;
          $display("FAIL b2b_last_spacing %0d: got %0d, want 8", j,
                   last_cyc[j] - last_cyc[j-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    stream(3, 2, 40, -1, -1);
    n_vec++;
    if (first_low_at != 16) begin
      n_err++;
      $display("FAIL bp_first_low: got after %0d accepts, want 16", first_low_at);
    end
    n_vec++;
    if (ready_low_cycles < 20) begin
      n_err++;
      $display("FAIL bp_low_cycles: got %0d, want >= 20", ready_low_cycles);
    end
  endtask

  task automatic test_random_stall();
    stream(2, 1, 0, -1, -1);
    n_vec++;
    if (last_cyc.size() != 2) begin
      n_err++;
      $display("FAIL stall_last_count: got %0d, want 2", last_cyc.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int v;
    enable = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      v = sample_val(frame_base, k);
      bus.in_valid = 1'b1;
      bus.in_r = DATA_W'(v);
      bus.in_i = DATA_W'(-v);
      #1;
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL partial_ready %0d: in_ready=%b, want 1", k, bus.in_ready);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b, want 0 1",
               bus.out_valid, bus.in_ready);
    end
    frame_base++;
    stream(1, 0, 0, -1, -1);
  endtask

  task automatic test_enable_gap();
    stream(2, 0, 0, 3, 13);
    n_vec++;
    if (last_cyc.size() != 2) begin
      n_err++;
      $display("FAIL gap_last_count: got %0d, want 2", last_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_mid_frame();
    test_enable_gap();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
